hci_bank_prio_arbiter: RTL and testbench
========================================

Name: hci_bank_prio_arbiter

Overview:
Per-bank two-way arbiter placed in front of each TCDM bank. It shares the single-ported bank between the log-interconnect branch (cores/DMA/ext) and the HWPE shallow branch. Priority between the two branches is selectable at runtime. A starvation counter forces a grant to the low-priority branch after a programmable number of consecutive stalls. The block also routes the one-cycle-latency bank response back to the branch that issued the access.

Parameters:
DW, 32, data width of a bank word (bits)
AW, 11, bank-local word address width (AddrMemWidth)
IW, 8, log-branch transaction ID width
CW, 8, width of the stall counter and of ctrl_max_stall_i
FILTER_WRITE_R_VALID, 0, if 1 no r_valid is returned for write accesses

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of all state
ctrl_invert_prio_i  in  1  0: HWPE high priority; 1: log high priority
ctrl_max_stall_i  in  CW  max consecutive low-prio stalls; 0 = strict priority
log_req_i / log_gnt_o  in/out  1  log-branch request/grant
log_add_i  in  AW  log word address
log_wen_i  in  1  1 = read, 0 = write
log_be_i  in  DW/8  byte enables
log_data_i  in  DW  write data
log_id_i  in  IW  transaction ID
log_r_valid_o  out  1  log response valid
log_r_data_o  out  DW  log read data
log_r_id_o  out  IW  echoed ID
hwpe_req_i / hwpe_gnt_o  in/out  1  HWPE request/grant
hwpe_add_i, hwpe_wen_i, hwpe_be_i, hwpe_data_i  in  AW/1/DW/8/DW  HWPE access fields
hwpe_r_valid_o  out  1  HWPE response valid
hwpe_r_data_o  out  DW  HWPE read data
mem_req_o  out  1  bank request
mem_add_o, mem_wen_o, mem_be_o, mem_data_o  out  AW/1/DW/8/DW  bank access fields
mem_r_data_i  in  DW  bank read data, valid the cycle after mem_req_o

Behaviour:
- Reset (rst_ni=0, asynchronous): stall_cnt=0, resp_pending=0, resp_sel=0, resp_id=0, resp_is_wr=0. All *_r_valid_o=0 and all r_data/r_id outputs are 0. gnt/mem outputs are combinational and 0 when there is no request.
- clear_i=1: same state values as reset, applied at the clock edge. Grants in that cycle still follow the arbitration rule below. Any response due in the next cycle is dropped.
- Definitions: hi = HWPE branch when ctrl_invert_prio_i=0, otherwise log branch. lo = the other branch.
- Grant rule (combinational, at most one grant per cycle):
  - force = (ctrl_max_stall_i!=0) && (stall_cnt >= ctrl_max_stall_i).
  - Only one branch requests: that branch is granted.
  - Both branches request: lo is granted if force, otherwise hi.
- mem_req_o = log_gnt_o | hwpe_gnt_o. The mem_add/wen/be/data outputs mux from the granted branch and are 0 when nothing is granted.
- Stall counter, updated at each edge:
  - lo requests and is not granted: stall_cnt += 1, saturating at 2^CW-1.
  - lo is granted, or lo does not request: stall_cnt = 0.
  - Changing ctrl_invert_prio_i also resets stall_cnt to 0 at the next edge (the stored previous value is compared).
- Response path, registered:
  - On a granted cycle: resp_pending=1, resp_sel=granted branch, resp_id=log_id_i (log branch only), resp_is_wr=~wen.
  - In the next cycle: the r_valid of the selected branch = resp_pending && !(FILTER_WRITE_R_VALID && resp_is_wr). r_data = mem_r_data_i for a read, 0 for a write. log_r_id_o = resp_id while log_r_valid_o is high, else 0.
  - Back-to-back grants produce back-to-back responses. There is no buffering and no backpressure on responses.
- Latency: grant is same cycle; response is exactly 1 cycle after grant.
- Simultaneous events: a priority flip in the same cycle as a contested request takes effect immediately for that grant.
- Requests must hold their fields stable until granted; the block does not latch unaccepted requests.

Test Plan:
- Reset mid-op: read granted at cycle N, rst_ni low at N+0.5 -> no r_valid at N+1, stall_cnt=0; after release the first contested cycle grants hi.
- Strict priority: ctrl_max_stall_i=0, both branches request for 20 cycles -> hwpe_gnt_o=1 every cycle, log_gnt_o=0; with ctrl_invert_prio_i=1 -> log granted every cycle.
- Starvation guard: ctrl_max_stall_i=3, both branches request continuously -> grant pattern H,H,H,L repeating; stall_cnt sequence 1,2,3,0.
- Response routing: log read, id=0x5A, addr 0x10, mem_r_data_i=0xDEADBEEF next cycle -> log_r_valid_o=1, log_r_data_o=0xDEADBEEF, log_r_id_o=0x5A, hwpe_r_valid_o=0.
- Write filtering: FILTER_WRITE_R_VALID=1, HWPE write to 0x7 -> mem_req_o=1, mem_wen_o=0, no hwpe_r_valid_o. With the parameter at 0 -> hwpe_r_valid_o=1 with r_data=0.
- Clear plus priority flip: stall_cnt=2, assert clear_i -> stall_cnt=0. Toggle ctrl_invert_prio_i while both branches request with max_stall=2 -> the new hi branch is granted and the counter restarts from 0.

Source files
------------

// File: rtl/hci_bank_prio_arbiter_if.sv
// Bundle of the three access ports around one TCDM bank: the log-interconnect
// branch, the HWPE shallow branch and the bank itself. The arbiter sits on the
// slave side; whatever drives requests and models the bank uses master.
interface hci_bank_prio_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 11,
  parameter int IW = 8
);
  // log-interconnect branch
  logic            log_req_i;
  logic            log_gnt_o;
  logic [AW-1:0]   log_add_i;
  logic            log_wen_i;
  logic [DW/8-1:0] log_be_i;
  logic [DW-1:0]   log_data_i;
  logic [IW-1:0]   log_id_i;
  logic            log_r_valid_o;
  logic [DW-1:0]   log_r_data_o;
  logic [IW-1:0]   log_r_id_o;

  // HWPE shallow branch
  logic            hwpe_req_i;
  logic            hwpe_gnt_o;
  logic [AW-1:0]   hwpe_add_i;
  logic            hwpe_wen_i;
  logic [DW/8-1:0] hwpe_be_i;
  logic [DW-1:0]   hwpe_data_i;
  logic            hwpe_r_valid_o;
  logic [DW-1:0]   hwpe_r_data_o;

  // single-ported bank
  logic            mem_req_o;
  logic [AW-1:0]   mem_add_o;
  logic            mem_wen_o;
  logic [DW/8-1:0] mem_be_o;
  logic [DW-1:0]   mem_data_o;
  logic [DW-1:0]   mem_r_data_i;

  modport slave (
    input  log_req_i, log_add_i, log_wen_i, log_be_i, log_data_i, log_id_i,
    output log_gnt_o, log_r_valid_o, log_r_data_o, log_r_id_o,
    input  hwpe_req_i, hwpe_add_i, hwpe_wen_i, hwpe_be_i, hwpe_data_i,
    output hwpe_gnt_o, hwpe_r_valid_o, hwpe_r_data_o,
    output mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
    input  mem_r_data_i
  );

  modport master (
    output log_req_i, log_add_i, log_wen_i, log_be_i, log_data_i, log_id_i,
    input  log_gnt_o, log_r_valid_o, log_r_data_o, log_r_id_o,
    output hwpe_req_i, hwpe_add_i, hwpe_wen_i, hwpe_be_i, hwpe_data_i,
    input  hwpe_gnt_o, hwpe_r_valid_o, hwpe_r_data_o,
    input  mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
    output mem_r_data_i
  );
endinterface

// File: rtl/hci_bank_prio_arbiter.sv
// Per-bank two-way arbiter in front of a TCDM bank. Shares the bank between
// the log-interconnect branch and the HWPE branch with runtime-selectable
// priority, a starvation guard that periodically lets the low-priority branch
// through, and routing of the one-cycle-latency bank response back to the
// branch that issued the access.
module hci_bank_prio_arbiter #(
  parameter int DW                   = 32,
  parameter int AW                   = 11,
  parameter int IW                   = 8,
  parameter int CW                   = 8,
  parameter int FILTER_WRITE_R_VALID = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          ctrl_invert_prio_i,
  input  logic [CW-1:0] ctrl_max_stall_i,
  hci_bank_prio_arbiter_if.slave bus
);

  localparam logic [CW-1:0] STALL_SAT = '1;

  typedef enum logic {
    SEL_LOG  = 1'b0,
    SEL_HWPE = 1'b1
  } sel_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_stall_cnt;
  logic          r_prio_q;       // priority setting seen at the previous edge
  logic          r_resp_pending;
  sel_e          r_resp_sel;
  logic [IW-1:0] r_resp_id;
  logic          r_resp_is_wr;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_hi_req;
  logic w_lo_req;
  logic w_force;
  logic w_gnt_hi;
  logic w_gnt_lo;
  logic w_prio_flip;

  // hi is HWPE unless the priority is inverted; lo is the other branch
  assign w_hi_req    = ctrl_invert_prio_i ? bus.log_req_i  : bus.hwpe_req_i;
  assign w_lo_req    = ctrl_invert_prio_i ? bus.hwpe_req_i : bus.log_req_i;
  assign w_force     = (ctrl_max_stall_i != '0) && (r_stall_cnt >= ctrl_max_stall_i);
  assign w_gnt_lo    = w_lo_req && (!w_hi_req || w_force);
  assign w_gnt_hi    = w_hi_req && !w_gnt_lo;
  assign w_prio_flip = (ctrl_invert_prio_i != r_prio_q);

  assign bus.log_gnt_o  = ctrl_invert_prio_i ? w_gnt_hi : w_gnt_lo;
  assign bus.hwpe_gnt_o = ctrl_invert_prio_i ? w_gnt_lo : w_gnt_hi;
  assign bus.mem_req_o  = bus.log_gnt_o | bus.hwpe_gnt_o;

  // Bank access fields follow the granted branch, zero when idle
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is never inferred.
    bus.mem_add_o  = '0;
    bus.mem_wen_o  = 1'b0;
    bus.mem_be_o   = '0;
    bus.mem_data_o = '0;
    if (bus.log_gnt_o) begin
      bus.mem_add_o  = bus.log_add_i;
      bus.mem_wen_o  = bus.log_wen_i;
      bus.mem_be_o   = bus.log_be_i;
      bus.mem_data_o = bus.log_data_i;
    end else if (bus.hwpe_gnt_o) begin
      bus.mem_add_o  = bus.hwpe_add_i;
      bus.mem_wen_o  = bus.hwpe_wen_i;
      bus.mem_be_o   = bus.hwpe_be_i;
      bus.mem_data_o = bus.hwpe_data_i;
    end
  end

  // Starvation counter: counts consecutive cycles lo waits behind hi
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the values from before this edge.
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_prio_q    <= 1'b0;
    end else if (clear_i) begin
      r_stall_cnt <= '0;
      // track the live setting so a clear is not followed by a spurious flip
      r_prio_q    <= ctrl_invert_prio_i;
    end else begin
      r_prio_q <= ctrl_invert_prio_i;
      if (w_prio_flip) begin
        r_stall_cnt <= '0;
      end else if (w_lo_req && !w_gnt_lo) begin
        if (r_stall_cnt != STALL_SAT) begin
          r_stall_cnt <= r_stall_cnt + CW'(1);
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  // Remember who owns the bank response arriving on the next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_pending <= 1'b0;
      r_resp_sel     <= SEL_LOG;
      r_resp_id      <= '0;
      r_resp_is_wr   <= 1'b0;
    end else if (clear_i) begin
      r_resp_pending <= 1'b0;
      r_resp_sel     <= SEL_LOG;
      r_resp_id      <= '0;
      r_resp_is_wr   <= 1'b0;
    end else begin
      r_resp_pending <= bus.mem_req_o;
      if (bus.mem_req_o) begin
        r_resp_sel   <= bus.hwpe_gnt_o ? SEL_HWPE : SEL_LOG;
        r_resp_id    <= bus.log_gnt_o ? bus.log_id_i : '0;
        r_resp_is_wr <= ~bus.mem_wen_o;
      end
    end
  end

  logic          w_resp_valid;
  logic [DW-1:0] w_resp_data;

  assign w_resp_valid = r_resp_pending && !((FILTER_WRITE_R_VALID != 0) && r_resp_is_wr);
  assign w_resp_data  = r_resp_is_wr ? '0 : bus.mem_r_data_i;

  // Steer the bank response to the branch that issued the access
  always_comb begin
    bus.log_r_valid_o  = 1'b0;
    bus.log_r_data_o   = '0;
    bus.log_r_id_o     = '0;
    bus.hwpe_r_valid_o = 1'b0;
    bus.hwpe_r_data_o  = '0;
    if (w_resp_valid) begin
      if (r_resp_sel == SEL_HWPE) begin
        bus.hwpe_r_valid_o = 1'b1;
        bus.hwpe_r_data_o  = w_resp_data;
      end else begin
        bus.log_r_valid_o  = 1'b1;
        bus.log_r_data_o   = w_resp_data;
        bus.log_r_id_o     = r_resp_id;
      end
    end
  end

endmodule

// File: tb/tb_hci_bank_prio_arbiter.sv
// Directed bench for hci_bank_prio_arbiter. Two instances share clock, reset
// and control: dut returns r_valid for writes, dut_f filters them.
module tb_hci_bank_prio_arbiter;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int IW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          invert;
  logic [CW-1:0] max_stall;

  int n_checks = 0;
  int n_fail   = 0;

  hci_bank_prio_arbiter_if #(.DW(DW), .AW(AW), .IW(IW)) bus   ();
  hci_bank_prio_arbiter_if #(.DW(DW), .AW(AW), .IW(IW)) bus_f ();

  hci_bank_prio_arbiter #(
    .DW(DW), .AW(AW), .IW(IW), .CW(CW), .FILTER_WRITE_R_VALID(0)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .clear_i            (clear),
    .ctrl_invert_prio_i (invert),
    .ctrl_max_stall_i   (max_stall),
    .bus                (bus.slave)
  );

  hci_bank_prio_arbiter #(
    .DW(DW), .AW(AW), .IW(IW), .CW(CW), .FILTER_WRITE_R_VALID(1)
  ) dut_f (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .clear_i            (clear),
    .ctrl_invert_prio_i (invert),
    .ctrl_max_stall_i   (max_stall),
    .bus                (bus_f.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    bus.log_req_i    = 1'b0; bus.log_add_i  = '0; bus.log_wen_i  = 1'b1;
    bus.log_be_i     = '0;   bus.log_data_i = '0; bus.log_id_i   = '0;
    bus.hwpe_req_i   = 1'b0; bus.hwpe_add_i = '0; bus.hwpe_wen_i = 1'b1;
    bus.hwpe_be_i    = '0;   bus.hwpe_data_i = '0;
    bus_f.log_req_i  = 1'b0; bus_f.log_add_i  = '0; bus_f.log_wen_i  = 1'b1;
    bus_f.log_be_i   = '0;   bus_f.log_data_i = '0; bus_f.log_id_i   = '0;
    bus_f.hwpe_req_i = 1'b0; bus_f.hwpe_add_i = '0; bus_f.hwpe_wen_i = 1'b1;
    bus_f.hwpe_be_i  = '0;   bus_f.hwpe_data_i = '0;
  endtask

  initial begin
    logic exp_l;
    logic prev_l;

    rst_n     = 1'b0;
    clear     = 1'b0;
    invert    = 1'b0;
    max_stall = '0;
    idle_all();
    bus.mem_r_data_i   = '0;
    bus_f.mem_r_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ---- reset state, nothing requesting
    check("rst_log_gnt",     bus.log_gnt_o,      0);
    check("rst_hwpe_gnt",    bus.hwpe_gnt_o,     0);
    check("rst_mem_req",     bus.mem_req_o,      0);
    check("rst_log_r_valid", bus.log_r_valid_o,  0);
    check("rst_hwpe_rvalid", bus.hwpe_r_valid_o, 0);
    check("rst_log_r_id",    bus.log_r_id_o,     0);
    check("rst_stall_cnt",   dut.r_stall_cnt,    0);

    // ---- response routing: log read id 0x5A at 0x10
    bus.log_req_i = 1'b1; bus.log_wen_i = 1'b1; bus.log_add_i = 11'h010;
    bus.log_id_i  = 8'h5A; bus.log_be_i = 4'hF;
    #1;
    check("rt_log_gnt",  bus.log_gnt_o,  1);
    check("rt_hwpe_gnt", bus.hwpe_gnt_o, 0);
    check("rt_mem_req",  bus.mem_req_o,  1);
    check("rt_mem_add",  bus.mem_add_o,  11'h010);
    check("rt_mem_wen",  bus.mem_wen_o,  1);
    tick();
    bus.log_req_i    = 1'b0;
    bus.mem_r_data_i = 32'hDEADBEEF;
    #1;
    check("rt_log_r_valid",  bus.log_r_valid_o,  1);
    check("rt_log_r_data",   bus.log_r_data_o,   32'hDEADBEEF);
    check("rt_log_r_id",     bus.log_r_id_o,     8'h5A);
    check("rt_hwpe_r_valid", bus.hwpe_r_valid_o, 0);
    check("rt_idle_mem_req", bus.mem_req_o,      0);
    tick();
    check("rt_after_valid",  bus.log_r_valid_o,  0);
    check("rt_after_id",     bus.log_r_id_o,     0);

    // ---- write filtering: HWPE write to 0x7 on both instances
    bus.hwpe_req_i   = 1'b1; bus.hwpe_wen_i   = 1'b0; bus.hwpe_add_i   = 11'h007;
    bus.hwpe_data_i  = 32'hCAFE0001; bus.hwpe_be_i = 4'hF;
    bus_f.hwpe_req_i = 1'b1; bus_f.hwpe_wen_i = 1'b0; bus_f.hwpe_add_i = 11'h007;
    bus_f.hwpe_data_i = 32'hCAFE0001; bus_f.hwpe_be_i = 4'hF;
    bus_f.mem_r_data_i = 32'h0BADF00D;
    #1;
    check("wr_mem_req",   bus.mem_req_o,   1);
    check("wr_mem_wen",   bus.mem_wen_o,   0);
    check("wr_mem_add",   bus.mem_add_o,   11'h007);
    check("wr_mem_data",  bus.mem_data_o,  32'hCAFE0001);
    check("wr_mem_be",    bus.mem_be_o,    4'hF);
    check("wrf_mem_req",  bus_f.mem_req_o, 1);
    check("wrf_mem_wen",  bus_f.mem_wen_o, 0);
    tick();
    bus.hwpe_req_i = 1'b0;
    bus_f.hwpe_wen_i = 1'b1;   // follow with an HWPE read on the filtered one
    #1;
    check("wr_hwpe_r_valid",  bus.hwpe_r_valid_o,   1);
    check("wr_hwpe_r_data",   bus.hwpe_r_data_o,    0);
    check("wr_log_r_valid",   bus.log_r_valid_o,    0);
    check("wrf_hwpe_r_valid", bus_f.hwpe_r_valid_o, 0);
    tick();
    bus_f.hwpe_req_i = 1'b0;
    #1;
    check("rdf_hwpe_r_valid", bus_f.hwpe_r_valid_o, 1);
    check("rdf_hwpe_r_data",  bus_f.hwpe_r_data_o,  32'h0BADF00D);

    // ---- strict priority, HWPE high
    bus.log_req_i  = 1'b1; bus.log_wen_i  = 1'b1; bus.log_add_i  = 11'h001; bus.log_id_i = 8'h01;
    bus.hwpe_req_i = 1'b1; bus.hwpe_wen_i = 1'b1; bus.hwpe_add_i = 11'h002;
    #1;
    check("strict_mem_add", bus.mem_add_o, 11'h002);
    for (int i = 0; i < 20; i++) begin
      check("strict_h_hwpe_gnt", bus.hwpe_gnt_o, 1);
      check("strict_h_log_gnt",  bus.log_gnt_o,  0);
      tick();
    end
    check("strict_h_stall", dut.r_stall_cnt, 20);

    // ---- strict priority, log high; the flip restarts the counter
    invert = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      check("strict_l_log_gnt",  bus.log_gnt_o,  1);
      check("strict_l_hwpe_gnt", bus.hwpe_gnt_o, 0);
      tick();
    end
    check("strict_l_stall", dut.r_stall_cnt, 19);

    // ---- starvation guard, max_stall=3: H,H,H,L repeating
    bus.log_req_i = 1'b0; bus.hwpe_req_i = 1'b0;
    invert    = 1'b0;
    max_stall = 8'd3;
    tick();
    bus.log_id_i  = 8'h33;
    bus.log_req_i = 1'b1; bus.hwpe_req_i = 1'b1;
    #1;
    prev_l = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_l = ((i % 4) == 3);
      check("starve_log_gnt",   bus.log_gnt_o,      exp_l);
      check("starve_hwpe_gnt",  bus.hwpe_gnt_o,     !exp_l);
      check("starve_log_rvld",  bus.log_r_valid_o,  prev_l);
      check("starve_log_rid",   bus.log_r_id_o,     prev_l ? 8'h33 : 8'h00);
      check("starve_hwpe_rvld", bus.hwpe_r_valid_o, (i > 0) && !prev_l);
      tick();
      check("starve_stall", dut.r_stall_cnt, exp_l ? 0 : (i % 4) + 1);
      prev_l = exp_l;
    end

    // ---- clear with counter at 2, then priority flip with max_stall=2
    bus.log_req_i = 1'b0; bus.hwpe_req_i = 1'b0;
    tick();
    bus.log_req_i = 1'b1; bus.hwpe_req_i = 1'b1;
    tick();
    tick();
    check("clr_stall_before", dut.r_stall_cnt, 2);
    clear = 1'b1;
    #1;
    check("clr_hwpe_gnt", bus.hwpe_gnt_o, 1);
    check("clr_log_gnt",  bus.log_gnt_o,  0);
    tick();
    clear = 1'b0;
    #1;
    check("clr_stall_after",     dut.r_stall_cnt,    0);
    check("clr_resp_dropped",    bus.hwpe_r_valid_o, 0);
    invert    = 1'b1;
    max_stall = 8'd2;
    #1;
    check("flip_log_gnt",  bus.log_gnt_o,  1);
    check("flip_hwpe_gnt", bus.hwpe_gnt_o, 0);
    tick();
    check("flip_stall0",     dut.r_stall_cnt,   0);
    check("flip_log_r_vld",  bus.log_r_valid_o, 1);
    check("flip_log_r_id",   bus.log_r_id_o,    8'h33);
    check("flip_log_gnt_1",  bus.log_gnt_o,     1);
    tick();
    check("flip_stall1",     dut.r_stall_cnt,   1);
    check("flip_log_gnt_2",  bus.log_gnt_o,     1);
    tick();
    check("flip_stall2",     dut.r_stall_cnt,   2);
    check("flip_force_hwpe", bus.hwpe_gnt_o,    1);
    check("flip_force_log",  bus.log_gnt_o,     0);
    tick();
    check("flip_stall_wrap", dut.r_stall_cnt,   0);

    // ---- reset in the middle of an access
    bus.log_req_i = 1'b0; bus.hwpe_req_i = 1'b0;
    invert    = 1'b0;
    max_stall = '0;
    tick();
    bus.log_req_i = 1'b1; bus.hwpe_req_i = 1'b1;
    tick();
    tick();
    tick();
    check("mid_stall",        dut.r_stall_cnt,    3);
    check("mid_hwpe_r_valid", bus.hwpe_r_valid_o, 1);
    #1;
    rst_n     = 1'b0;
    max_stall = 8'd1;
    #1;
    check("mid_rst_hwpe_rvld", bus.hwpe_r_valid_o, 0);
    check("mid_rst_log_rvld",  bus.log_r_valid_o,  0);
    check("mid_rst_stall",     dut.r_stall_cnt,    0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("mid_post_hwpe_gnt", bus.hwpe_gnt_o, 1);
    check("mid_post_log_gnt",  bus.log_gnt_o,  0);
    tick();
    check("mid_post_force_log", bus.log_gnt_o, 1);

    idle_all();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
